// File: rtl/pll_dyn_ctrl_pkg.sv
// pll_dyn_ctrl_pkg: shared types and power-up divider values for pll_dyn_ctrl.
// Rev 1.0
`default_nettype none

package pll_dyn_ctrl_pkg;

    typedef logic [5:0] div_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_ERROR     = 3'd4
    } state_t;

    localparam div_t DEF_IDIV  = 6'd2;
    localparam div_t DEF_FBDIV = 6'd7;
    localparam div_t DEF_ODIV  = 6'd16;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
// Rev 1.0
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: dynamic PLL divider update with reset pulse and qualified relock.
// Optional lock timeout / ERROR retry enabled by macro PLL_LOCK_TIMEOUT_EN. Rev 1.0
`default_nettype none

module pll_dyn_ctrl
    import pll_dyn_ctrl_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_idiv,
    input  logic [5:0] req_fbdiv,
    input  logic [5:0] req_odiv,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       pll_rst,
    input  logic       pll_lock,
    output logic       locked,
    output logic       done,
    output logic       err
);

    localparam int RST_W = $clog2(RST_CYCLES) + 1;
    localparam int STB_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);

    if (RST_CYCLES < 1 || STABLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("pll_dyn_ctrl: cycle parameters must be at least 1");
    end

    state_t             r_state;
    div_t               r_idiv;
    div_t               r_fbdiv;
    div_t               r_odiv;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [STB_W-1:0]   r_stb_cnt;
    logic               r_boot;
    logic               r_locked;
    logic               r_done;
    logic               w_lock_s;
    logic               w_waiting;
    logic               w_finish;
    logic               w_timeout;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (w_lock_s)
    );

    assign w_waiting = (r_state == ST_WAIT_LOCK) || (r_state == ST_STABLE);
    assign w_finish  = w_waiting && w_lock_s && (r_stb_cnt >= STB_LAST);

    assign req_ready  = (r_state == ST_IDLE) && !r_boot;
    // Boot IDLE cycle keeps the PLL in reset until the automatic sequence starts.
    assign pll_rst    = (r_state == ST_RESET) || (r_state == ST_ERROR) ||
                        ((r_state == ST_IDLE) && r_boot);
    assign pll_idsel  = ~r_idiv;
    assign pll_fbdsel = ~r_fbdiv;
    assign pll_odsel  = ~r_odiv;
    assign locked     = r_locked;
    assign done       = r_done;

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    assign w_timeout = w_waiting && (r_to_cnt >= TO_LAST);
    assign err       = r_err;

    // Spans WAIT_LOCK and STABLE, so a lock glitch does not restart the budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_timeout && !w_finish;
            if (!w_waiting) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != '1) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idiv    <= DEF_IDIV;
            r_fbdiv   <= DEF_FBDIV;
            r_odiv    <= DEF_ODIV;
            r_rst_cnt <= '0;
            r_stb_cnt <= '0;
            r_boot    <= 1'b1;
            r_locked  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_lock_s) begin
                        r_locked <= 1'b0;
                    end
                    if (r_boot) begin
                        r_boot    <= 1'b0;
                        r_rst_cnt <= '0;
                        r_state   <= ST_RESET;
                    end else if (req_valid) begin
                        r_idiv    <= req_idiv;
                        r_fbdiv   <= req_fbdiv;
                        r_odiv    <= req_odiv;
                        r_locked  <= 1'b0;
                        r_rst_cnt <= '0;
                        r_state   <= ST_RESET;
                    end
                end
                ST_RESET: begin
                    if (r_rst_cnt >= RST_LAST) begin
                        r_stb_cnt <= '0;
                        r_state   <= ST_WAIT_LOCK;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK, ST_STABLE: begin
                    if (w_finish) begin
                        r_done   <= 1'b1;
                        r_locked <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else if (w_timeout) begin
                        r_state <= ST_ERROR;
                    end else if (w_lock_s) begin
                        r_stb_cnt <= r_stb_cnt + 1'b1;
                        r_state   <= ST_STABLE;
                    end else begin
                        r_stb_cnt <= '0;
                        r_state   <= ST_WAIT_LOCK;
                    end
                end
`ifdef PLL_LOCK_TIMEOUT_EN
                ST_ERROR: begin
                    r_rst_cnt <= '0;
                    r_state   <= ST_RESET;
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pll_dyn_ctrl.sv
// tb_pll_dyn_ctrl: directed, table-driven bench for pll_dyn_ctrl.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_pll_dyn_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_idiv, req_fbdiv, req_odiv;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       pll_rst, pll_lock, locked, done, err;

    logic       t_rst;
    logic       t_req_valid = 1'b0;
    logic       t_req_ready;
    logic [5:0] t_idsel, t_fbdsel, t_odsel;
    logic       t_pll_rst, t_locked, t_done, t_err;
    logic       t_lock = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pll_dyn_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_idiv(req_idiv), .req_fbdiv(req_fbdiv), .req_odiv(req_odiv),
        .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
        .pll_rst(pll_rst), .pll_lock(pll_lock),
        .locked(locked), .done(done), .err(err)
    );

    pll_dyn_ctrl #(.TIMEOUT_CYCLES(100)) dut_to (
        .clk(clk), .rst(t_rst),
        .req_valid(t_req_valid), .req_ready(t_req_ready),
        .req_idiv(6'd0), .req_fbdiv(6'd0), .req_odiv(6'd0),
        .pll_idsel(t_idsel), .pll_fbdsel(t_fbdsel), .pll_odsel(t_odsel),
        .pll_rst(t_pll_rst), .pll_lock(t_lock),
        .locked(t_locked), .done(t_done), .err(t_err)
    );

    typedef struct {
        logic [5:0] idiv, fbdiv, odiv;
        logic [5:0] e_id, e_fb, e_od;
        int         delay;
    } vec_t;

    vec_t vecs[3];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
        req_idiv  = i;
        req_fbdiv = f;
        req_odiv  = o;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        pll_lock  = 1'b0;
    endtask

    task automatic wait_rst_low(output int hi);
        hi = 0;
        while (pll_rst === 1'b1 && hi < 100) begin
            hi++;
            tick;
        end
    endtask

    task automatic wait_done(output int n, output logic early);
        n = 0;
        early = 1'b0;
        do begin
            tick;
            n++;
            if (!done && locked) early = 1'b1;
        end while (done !== 1'b1 && n < 200);
    endtask

    initial begin
        int   hi, n;
        logic early, seen;

        vecs[0] = '{6'd3,  6'd9,  6'd8, 6'b111100, 6'b110110, 6'b110111, 40};
        vecs[1] = '{6'd0,  6'd63, 6'd1, 6'b111111, 6'b000000, 6'b111110, 0};
        vecs[2] = '{6'd42, 6'd21, 6'd5, 6'b010101, 6'b101010, 6'b111010, 7};

        rst = 1'b1; t_rst = 1'b1; req_valid = 1'b0; pll_lock = 1'b0;
        req_idiv = '0; req_fbdiv = '0; req_odiv = '0;
        tick; tick;

        check("rst_pll_rst", 32'(pll_rst), 1);
        check("rst_locked", 32'(locked), 0);
        check("rst_done_err", 32'({done, err}), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_idsel", 32'(pll_idsel), 32'(6'b111101));
        check("rst_odsel", 32'(pll_odsel), 32'(6'b101111));

        // Automatic power-up sequence
        rst = 1'b0;
        wait_rst_low(hi);
        check("boot_rst_falls", 32'(hi < 100), 1);
        repeat (40) tick;
        check("boot_ready_wait", 32'(req_ready), 0);
        check("boot_fbdsel", 32'(pll_fbdsel), 32'(6'b111000));
        pll_lock = 1'b1;
        wait_done(n, early);
        check("boot_done_lat", 32'(n), 66);
        check("boot_locked", 32'(locked), 1);
        check("boot_ready", 32'(req_ready), 1);
        check("boot_early_lock", 32'(early), 0);

        // Lock loss in IDLE: clears locked after sync latency, no relock
        pll_lock = 1'b0;
        tick; tick;
        check("idle_drop_lat2", 32'(locked), 1);
        tick;
        check("idle_drop_lat3", 32'(locked), 0);
        repeat (5) tick;
        check("idle_no_relock", 32'({pll_rst, req_ready}), 32'(2'b01));

        for (int v = 0; v < 3; v++) begin
            check("vec_ready", 32'(req_ready), 1);
            issue(vecs[v].idiv, vecs[v].fbdiv, vecs[v].odiv);
            check("vec_idsel", 32'(pll_idsel), 32'(vecs[v].e_id));
            check("vec_fbdsel", 32'(pll_fbdsel), 32'(vecs[v].e_fb));
            check("vec_odsel", 32'(pll_odsel), 32'(vecs[v].e_od));
            check("vec_locked_clr", 32'(locked), 0);
            wait_rst_low(hi);
            check("vec_rst_len", 32'(hi), 16);
            repeat (vecs[v].delay) tick;
            pll_lock = 1'b1;
            wait_done(n, early);
            check("vec_done_lat", 32'(n), 66);
            check("vec_locked", 32'(locked), 1);
            check("vec_early_lock", 32'(early), 0);
            tick;
            check("vec_done_pulse", 32'(done), 0);
        end

        // One-cycle lock glitch mid-STABLE restarts the stable count
        issue(6'd3, 6'd9, 6'd8);
        wait_rst_low(hi);
        pll_lock = 1'b1;
        seen = 1'b0;
        repeat (29) begin
            tick;
            if (done) seen = 1'b1;
        end
        pll_lock = 1'b0;
        tick;
        pll_lock = 1'b1;
        wait_done(n, early);
        check("glitch_no_early_done", 32'(seen), 0);
        check("glitch_done_lat", 32'(n), 66);

        // Request during WAIT_LOCK is dropped, not queued
        issue(6'd5, 6'd10, 6'd20);
        wait_rst_low(hi);
        req_idiv = 6'd1; req_fbdiv = 6'd1; req_odiv = 6'd1;
        req_valid = 1'b1;
        repeat (3) tick;
        check("ign_ready", 32'(req_ready), 0);
        check("ign_idsel", 32'(pll_idsel), 32'(6'b111010));
        req_valid = 1'b0;
        pll_lock = 1'b1;
        wait_done(n, early);
        check("ign_done_lat", 32'(n), 66);
        check("ign_sel_kept", 32'({pll_idsel, pll_fbdsel, pll_odsel}),
              32'({6'b111010, 6'b110101, 6'b101011}));
        repeat (4) tick;
        check("ign_no_queue", 32'({pll_rst, req_ready}), 32'(2'b01));

        // rst asserted mid-RESET aborts and restores defaults
        issue(6'd3, 6'd9, 6'd8);
        repeat (5) tick;
        rst = 1'b1;
        tick;
        check("abort_pll_rst", 32'(pll_rst), 1);
        check("abort_status", 32'({locked, done, req_ready}), 0);
        check("abort_sel_def", 32'({pll_idsel, pll_fbdsel, pll_odsel}),
              32'({6'b111101, 6'b111000, 6'b101111}));
        rst = 1'b0;
        wait_rst_low(hi);
        check("abort_restart_ready", 32'(req_ready), 0);
        check("abort_sel_kept", 32'(pll_fbdsel), 32'(6'b111000));
        repeat (3) tick;
        pll_lock = 1'b1;
        wait_done(n, early);
        check("abort_done_lat", 32'(n), 66);
        check("abort_locked", 32'(locked), 1);

        // Lock never rises on the second instance
        t_rst = 1'b0;
        hi = 0;
        while (t_pll_rst === 1'b1 && hi < 100) begin
            hi++;
            tick;
        end
        check("to_rst_falls", 32'(hi < 100), 1);
`ifdef PLL_LOCK_TIMEOUT_EN
        n = 0;
        do begin
            tick;
            n++;
        end while (t_err !== 1'b1 && n < 300);
        check("to_err_lat", 32'(n), 100);
        check("to_err_pll_rst", 32'(t_pll_rst), 1);
        tick;
        check("to_err_pulse", 32'(t_err), 0);
        hi = 0;
        while (t_pll_rst === 1'b1 && hi < 100) begin
            hi++;
            tick;
        end
        check("to_retry_rst_len", 32'(hi), 16);
        check("to_retry_sel", 32'(t_fbdsel), 32'(6'b111000));
        check("to_retry_ready", 32'(t_req_ready), 0);
`else
        seen = 1'b0;
        repeat (150) begin
            tick;
            if (t_err || t_pll_rst) seen = 1'b1;
        end
        check("noto_waits", 32'(seen), 0);
        check("noto_ready", 32'(t_req_ready), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pll_dyn_ctrl.md
PLL_DYN_CTRL -- requirements
Module: pll_dyn_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16, length in clk cycles of the PLL reset pulse.
REQ-002 SHALL have parameter STABLE_CYCLES, default 64, number of consecutive clk cycles synchronized lock must hold.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum clk cycles waiting for lock.
REQ-004 clk  input  1  single clock, the 27 MHz board clock feeding the PLL; everything is clocked on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  request for a new divider set.
REQ-007 req_ready  output  1  high only in IDLE.
REQ-008 req_idiv / req_fbdiv / req_odiv  input  6 each  divider values, 0..63.
REQ-009 pll_idsel / pll_fbdsel / pll_odsel  output  6 each  select codes to the PLL, each the bitwise inverse of the stored value.
REQ-010 pll_rst  output  1  PLL reset, active-high.
REQ-011 pll_lock  input  1  raw PLL LOCK, asynchronous to clk.
REQ-012 locked  output  1  synchronized, qualified lock status.
REQ-013 done  output  1  one-cycle pulse on successful relock.
REQ-014 err  output  1  one-cycle pulse on lock timeout.

Function
REQ-015 States SHALL be IDLE, RESET, WAIT_LOCK, STABLE and ERROR.
REQ-016 Handshake: request accepted when req_valid && req_ready; all three divider values captured that cycle.
REQ-017 Accepted request: go to RESET next cycle, with pll_rst=1 and the new select codes driven.
REQ-018 RESET: hold exactly RST_CYCLES cycles, then go to WAIT_LOCK with pll_rst=0.
REQ-019 Select codes SHALL change only on acceptance and SHALL stay constant until the next acceptance.
REQ-020 pll_lock SHALL pass through a 2-FF synchronizer; latency raw to synced is 2 cycles.
REQ-021 WAIT_LOCK: synced lock=1 moves to STABLE.
REQ-022 STABLE: counts consecutive synced-lock cycles; reaching STABLE_CYCLES gives done=1 and IDLE in the same cycle.
REQ-023 STABLE: any synced-lock=0 SHALL return to WAIT_LOCK, with the stable count cleared and the timeout count not cleared.
REQ-024 locked SHALL be 1 only in IDLE after a successful done, and 0 from acceptance onward.
REQ-025 In IDLE, synced lock dropping SHALL clear locked but SHALL NOT start a relock.
REQ-026 req_valid outside IDLE SHALL be ignored, with no queuing.
REQ-027 Counters SHALL be sized with $clog2 of their parameter + 1 and SHALL saturate, never wrap.

Reset
REQ-028 On rst: state IDLE, pll_rst=1, locked=0, done=0, err=0, counters 0.
REQ-029 On rst, the stored dividers SHALL take the power-up values idiv=2, fbdiv=7, odiv=16.
REQ-030 After rst deasserts, the block SHALL perform one automatic RESET/WAIT_LOCK/STABLE sequence with those values; req_ready stays 0 until it finishes.
REQ-031 rst mid-sequence SHALL abort immediately, and the pending request SHALL be discarded.

Configuration
REQ-032 Macro PLL_LOCK_TIMEOUT_EN, when defined: a timeout counter runs in WAIT_LOCK and STABLE; reaching TIMEOUT_CYCLES gives err=1 for one cycle, then ERROR.
REQ-033 ERROR SHALL drive pll_rst=1 for one cycle, then re-enter RESET with the same dividers; req_ready stays 0.
REQ-034 Macro PLL_LOCK_TIMEOUT_EN, when undefined: no timeout counter and no ERROR state; err is tied 0; WAIT_LOCK waits indefinitely.

Structure
REQ-035 A shared package SHALL hold the state enum, the reset-default divider constants (2/7/16) and the 6-bit divider typedef.
REQ-036 The 2-FF lock synchronizer SHALL be a sub-module named sync_2ff.

Verification
REQ-037 Reset release, lock raised 40 cycles after pll_rst falls -> pll_fbdsel=6'b111000, done 2+64 cycles after the lock edge, locked=1, req_ready=1.
REQ-038 Request idiv=3/fbdiv=9/odiv=8 in IDLE -> pll_rst high exactly 16 cycles, pll_idsel=6'b111100, pll_fbdsel=6'b110110, pll_odsel=6'b110111, locked=0 until done.
REQ-039 Lock glitches low for 1 cycle at stable count 30 -> no done; done occurs 64 synced-lock cycles after recovery.
REQ-040 Timeout, with PLL_LOCK_TIMEOUT_EN defined and TIMEOUT_CYCLES=100, lock never rises -> err pulse at cycle 100 of waiting, then pll_rst reasserted and the sequence retried.
REQ-041 Second req_valid during WAIT_LOCK -> ignored, select codes unchanged; rst asserted mid-RESET -> IDLE defaults, pll_rst=1, then the automatic sequence restarts.
